// File: rtl/full_handshake_pkg.sv
// Shared defaults and FSM state encodings for the four-phase req/ack transfer block.
package full_handshake_pkg;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      T_IDLE        = 2'd0,
      T_WAIT_ACK_HI = 2'd1,
      T_WAIT_ACK_LO = 2'd2
   } tx_state_t;

   typedef enum logic {
      R_IDLE        = 1'b0,
      R_WAIT_REQ_LO = 1'b1
   } rx_state_t;

endpackage

// File: rtl/full_handshake_sync.sv
// Single-bit flop synchronizer chain, STAGES deep, async active-low reset to 0.
module full_handshake_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/full_handshake_top.sv
// Four-phase req/ack word transfer with synchronized req/ack paths.
// Optional FULL_HANDSHAKE_RDY_EN adds a registered din_rdy output.
module full_handshake_top
   import full_handshake_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din_val,
   input  logic [DATA_W-1:0] din,
`ifdef FULL_HANDSHAKE_RDY_EN
   output logic              din_rdy,
`endif
   output logic              dout_val,
   output logic [DATA_W-1:0] dout
);

   tx_state_t         tx_state, tx_state_d;
   rx_state_t         rx_state, rx_state_d;
   logic              req_q, req_d;
   logic              ack_q, ack_d;
   logic              req_sync, ack_sync;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] dout_d;
   logic              dout_val_d;

   full_handshake_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_q),
      .q     (req_sync)
   );

   full_handshake_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ack_q),
      .q     (ack_sync)
   );

   // TX: data_q is only written on the capture edge, so RX may read it unsynchronized.
   always_comb begin
      tx_state_d = tx_state;
      req_d      = req_q;
      data_d     = data_q;
      case (tx_state)
         T_IDLE: begin
            if (din_val) begin
               data_d     = din;
               req_d      = 1'b1;
               tx_state_d = T_WAIT_ACK_HI;
            end
         end
         T_WAIT_ACK_HI: begin
            if (ack_sync) begin
               req_d      = 1'b0;
               tx_state_d = T_WAIT_ACK_LO;
            end
         end
         T_WAIT_ACK_LO: begin
            if (!ack_sync) begin
               tx_state_d = T_IDLE;
            end
         end
         default: begin
            req_d      = 1'b0;
            tx_state_d = T_IDLE;
         end
      endcase
   end

   // RX: deliver on req rise, release ack once req has fallen.
   always_comb begin
      rx_state_d = rx_state;
      ack_d      = ack_q;
      dout_d     = dout;
      dout_val_d = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (req_sync) begin
               dout_d     = data_q;
               dout_val_d = 1'b1;
               ack_d      = 1'b1;
               rx_state_d = R_WAIT_REQ_LO;
            end
         end
         R_WAIT_REQ_LO: begin
            if (!req_sync) begin
               ack_d      = 1'b0;
               rx_state_d = R_IDLE;
            end
         end
         default: begin
            ack_d      = 1'b0;
            rx_state_d = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= T_IDLE;
         rx_state <= R_IDLE;
         req_q    <= 1'b0;
         ack_q    <= 1'b0;
         data_q   <= '0;
         dout     <= '0;
         dout_val <= 1'b0;
      end else begin
         tx_state <= tx_state_d;
         rx_state <= rx_state_d;
         req_q    <= req_d;
         ack_q    <= ack_d;
         data_q   <= data_d;
         dout     <= dout_d;
         dout_val <= dout_val_d;
      end
   end

`ifdef FULL_HANDSHAKE_RDY_EN
   // Registered from next state so it is low in reset and tracks T_IDLE afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_rdy <= 1'b0;
      end else begin
         din_rdy <= (tx_state_d == T_IDLE);
      end
   end
`endif

endmodule

// File: tb/tb_full_handshake_top.sv
// Directed self-checking bench for full_handshake_top; set S to match SYNC_STAGES.
module tb_full_handshake_top;

   localparam int unsigned W   = 32;
   localparam int unsigned S   = 2;
   localparam int          LAT = S + 1;
   localparam int          PER = 4 * S + 5;

   logic          clk;
   logic          rst_n;
   logic          din_val;
   logic [W-1:0]  din;
   logic          dout_val;
   logic [W-1:0]  dout;
`ifdef FULL_HANDSHAKE_RDY_EN
   logic          din_rdy;
`endif

   int total = 0;
   int bad   = 0;

   full_handshake_top #(.DATA_W(W), .SYNC_STAGES(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_val  (din_val),
      .din      (din),
`ifdef FULL_HANDSHAKE_RDY_EN
      .din_rdy  (din_rdy),
`endif
      .dout_val (dout_val),
      .dout     (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_cycles(input int n);
      din_val = 1'b0;
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      din_val = 1'b1;
      din     = 32'h1234;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (dout !== 32'h0 || dout_val !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: dout=%h dout_val=%b want dout=0 dout_val=0", dout, dout_val);
         end
      end
      din_val = 1'b0;
      rst_n   = 1'b1;
      for (int i = 0; i < PER + 5; i++) begin
         @(negedge clk);
         total++;
         if (dout_val !== 1'b0 || dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_release: cyc=%0d dout=%h dout_val=%b want 0/0", i, dout, dout_val);
         end
      end
   endtask

   task automatic test_single_word;
      din     = 32'h0000_ABCD;
      din_val = 1'b1;
      for (int k = 0; k < LAT + 21; k++) begin
         @(negedge clk);
         if (k == 0) begin
            din_val = 1'b0;
            din     = 32'hDEAD_0000;
         end
         total++;
         if (dout_val !== (k == LAT)) begin
            bad++;
            $display("FAIL single_val: k=%0d dout_val=%b want %b", k, dout_val, (k == LAT));
         end
         if (k >= LAT) begin
            total++;
            if (dout !== 32'h0000_ABCD) begin
               bad++;
               $display("FAIL single_data: k=%0d dout=%h want 0000abcd", k, dout);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int pulses;
      pulses  = 0;
      din     = 32'h0;
      din_val = 1'b1;
      for (int k = 0; k < 4 * PER + 3; k++) begin
         @(negedge clk);
         din = 32'(k + 1);
         total++;
         if (dout_val !== ((k % PER) == LAT)) begin
            bad++;
            $display("FAIL stream_val: k=%0d dout_val=%b want %b", k, dout_val, ((k % PER) == LAT));
         end
         if (dout_val === 1'b1) begin
            pulses++;
            total++;
            if (dout !== 32'(k - LAT)) begin
               bad++;
               $display("FAIL stream_data: k=%0d dout=%h want %h", k, dout, 32'(k - LAT));
            end
         end
      end
      total++;
      if (pulses != 4) begin
         bad++;
         $display("FAIL stream_count: pulses=%0d want 4", pulses);
      end
      idle_cycles(PER + 4);
   endtask

   task automatic test_busy_drop;
      int pulses;
      pulses  = 0;
      din     = 32'h1111;
      din_val = 1'b1;
      for (int k = 0; k < 2 * PER + 4; k++) begin
         @(negedge clk);
         if (k == 0) begin
            din = 32'h2222;
         end else if (k == 1) begin
            din_val = 1'b0;
         end
         total++;
         if (dout_val !== (k == LAT)) begin
            bad++;
            $display("FAIL busy_val: k=%0d dout_val=%b want %b", k, dout_val, (k == LAT));
         end
         if (dout_val === 1'b1) pulses++;
      end
      total++;
      if (dout !== 32'h1111 || pulses != 1) begin
         bad++;
         $display("FAIL busy_data: dout=%h pulses=%0d want 00001111 1", dout, pulses);
      end
   endtask

   task automatic test_mid_reset;
      din     = 32'h9999;
      din_val = 1'b1;
      @(negedge clk);
      din_val = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (dout !== 32'h0 || dout_val !== 1'b0) begin
            bad++;
            $display("FAIL midrst_hold: dout=%h dout_val=%b want 0/0", dout, dout_val);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         total++;
         if (dout !== 32'h0 || dout_val !== 1'b0) begin
            bad++;
            $display("FAIL midrst_nodeliver: cyc=%0d dout=%h dout_val=%b want 0/0", i, dout, dout_val);
         end
      end
      din     = 32'h55AA;
      din_val = 1'b1;
      for (int k = 0; k < PER; k++) begin
         @(negedge clk);
         if (k == 0) din_val = 1'b0;
         total++;
         if (dout_val !== (k == LAT)) begin
            bad++;
            $display("FAIL midrst_val: k=%0d dout_val=%b want %b", k, dout_val, (k == LAT));
         end
         if (k == LAT) begin
            total++;
            if (dout !== 32'h55AA) begin
               bad++;
               $display("FAIL midrst_data: dout=%h want 000055aa", dout);
            end
         end
      end
   endtask

`ifdef FULL_HANDSHAKE_RDY_EN
   task automatic test_rdy;
      total++;
      if (din_rdy !== 1'b1) begin
         bad++;
         $display("FAIL rdy_idle: din_rdy=%b want 1", din_rdy);
      end
      din     = 32'h7777;
      din_val = 1'b1;
      for (int k = 0; k < PER + 2; k++) begin
         @(negedge clk);
         if (k == 0) din_val = 1'b0;
         total++;
         if (din_rdy !== (k >= PER - 1)) begin
            bad++;
            $display("FAIL rdy_track: k=%0d din_rdy=%b want %b", k, din_rdy, (k >= PER - 1));
         end
      end
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      din_val = 1'b0;
      din     = '0;
      @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_busy_drop();
      test_mid_reset();
`ifdef FULL_HANDSHAKE_RDY_EN
      idle_cycles(2);
      test_rdy();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
